axi4_m_r_mo: RTL and testbench

AXI4_M_R_MO -- requirements
Module: axi4_m_r_mo

---
 rtl/axi4_m_r_mo.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_axi4_m_r_mo.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_m_r_mo.sv
// AXI4 read master: queues requests, tracks up to NOUT outstanding IDs, splits bursts at
// 4KB boundaries and returns R beats through a one-entry completion stage.
module axi4_m_r_mo #(
  parameter int TAGW = 3,
  parameter int ADRW = 32,
  parameter int DATW = 256,
  parameter int NOUT = 4,
  parameter int REQD = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADRW-1:0]       req_addr,
  input  logic [7:0]            req_len,
  input  logic [2:0]            req_size,
  input  logic [TAGW-1:0]       req_tag,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic [TAGW-1:0]       o_m_arid,
  output logic [ADRW-1:0]       o_m_araddr,
  output logic [7:0]            o_m_arlen,
  output logic [2:0]            o_m_arsize,
  output logic [1:0]            o_m_arburst,
  output logic                  o_m_arlock,
  output logic [3:0]            o_m_arcache,
  output logic [2:0]            o_m_arprot,
  output logic [3:0]            o_m_arregion,
  output logic                  o_m_arvalid,
  input  logic                  i_m_arready,
  input  logic [TAGW-1:0]       i_m_rid,
  input  logic [DATW-1:0]       i_m_rdata,
  input  logic [1:0]            i_m_rresp,
  input  logic                  i_m_rlast,
  input  logic                  i_m_rvalid,
  output logic                  o_m_rready,
  output logic                  cpl_valid,
  input  logic                  cpl_ready,
  output logic [TAGW-1:0]       cpl_tag,
  output logic [DATW-1:0]       cpl_data,
  output logic [1:0]            cpl_resp,
  output logic                  cpl_last,
  output logic [$clog2(NOUT):0] o_outstanding,
  output logic [7:0]            o_unexp_cnt
);

  localparam int STBW  = DATW / 8;
  localparam int MAXSZ = $clog2(STBW);
  localparam int PW    = (REQD > 1) ? $clog2(REQD) : 1;
  localparam int CW    = $clog2(REQD) + 1;
  localparam int SW    = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int OCW   = $clog2(NOUT) + 1;

  typedef enum logic [1:0] {AR_IDLE, AR_ONE, AR_TWO} ar_state_t;

  logic [ADRW-1:0] fifo_addr_r [REQD];
  logic [7:0]      fifo_len_r  [REQD];
  logic [2:0]      fifo_size_r [REQD];
  logic [TAGW-1:0] fifo_tag_r  [REQD];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   cnt_r, cnt_nxt_s;
  logic            req_ready_r, rdy_en_r;
  logic            push_s, pop_s, pop_ar_s, pop_err_s, fifo_ne_s;

  logic [ADRW-1:0] head_addr_s, end_s, len_p1_s, addr2_s;
  logic [7:0]      head_len_s, len1_s, len2_s;
  logic [2:0]      head_size_s;
  logic [TAGW-1:0] head_tag_s;
  logic [12:0]     room_s;
  logic            cross_s, size_bad_s;

  ar_state_t       state_r, state_s;
  logic            arvalid_r, split_r;
  logic [TAGW-1:0] arid_r;
  logic [ADRW-1:0] araddr_r, addr2_r;
  logic [7:0]      arlen_r, len2_r;
  logic [2:0]      arsize_r;

  logic [NOUT-1:0] busy_r;
  logic [TAGW-1:0] slot_tag_r    [NOUT];
  logic [1:0]      slot_pieces_r [NOUT];
  logic [SW-1:0]   free_slot_s, rid_idx_s;
  logic            free_found_s, rid_in_s, rid_busy_s, last_piece_s;
  logic            r_acc_s, hit_s, unexp_s, slot_free_s, cpl_free_s;

  logic            cpl_valid_r, cpl_last_r;
  logic [TAGW-1:0] cpl_tag_r;
  logic [DATW-1:0] cpl_data_r;
  logic [1:0]      cpl_resp_r;
  logic [OCW-1:0]  out_cnt_r;
  logic [7:0]      unexp_cnt_r;

  assign push_s      = req_valid && req_ready_r;
  assign pop_s       = pop_ar_s || pop_err_s;
  assign fifo_ne_s   = (cnt_r != '0);
  assign cnt_nxt_s   = cnt_r + CW'(push_s) - CW'(pop_s);
  assign head_addr_s = fifo_addr_r[rd_ptr_r];
  assign head_len_s  = fifo_len_r[rd_ptr_r];
  assign head_size_s = fifo_size_r[rd_ptr_r];
  assign head_tag_s  = fifo_tag_r[rd_ptr_r];

  // Burst geometry of the FIFO head: end address, 4KB crossing and the two split pieces.
  assign len_p1_s   = ADRW'(head_len_s) + ADRW'(1);
  assign end_s      = head_addr_s + (len_p1_s << head_size_s) - ADRW'(1);
  assign cross_s    = (end_s[ADRW-1:12] != head_addr_s[ADRW-1:12]);
  assign room_s     = 13'd4096 - {1'b0, head_addr_s[11:0]};
  assign len1_s     = 8'((room_s >> head_size_s) - 13'd1);
  assign len2_s     = head_len_s - len1_s - 8'd1;
  assign addr2_s    = {head_addr_s[ADRW-1:12] + (ADRW-12)'(1), 12'h000};
  assign size_bad_s = (head_size_s > 3'(MAXSZ));

  assign cpl_free_s   = !cpl_valid_r || cpl_ready;
  assign o_m_rready   = rdy_en_r && cpl_free_s;
  assign r_acc_s      = i_m_rvalid && o_m_rready;
  assign rid_in_s     = (32'(i_m_rid) < 32'(NOUT));
  assign rid_idx_s    = SW'(i_m_rid);
  assign rid_busy_s   = rid_in_s && busy_r[rid_idx_s];
  assign last_piece_s = (slot_pieces_r[rid_idx_s] == 2'd1);
  assign hit_s        = r_acc_s && rid_busy_s;
  assign unexp_s      = r_acc_s && !rid_busy_s;
  assign slot_free_s  = hit_s && i_m_rlast && last_piece_s;

  // Lowest-numbered free slot; a slot freed this cycle is still busy here.
  always_comb begin
    free_slot_s  = '0;
    free_found_s = |(~busy_r);
    for (int i = NOUT - 1; i >= 0; i--) begin
      free_slot_s = busy_r[i] ? free_slot_s : SW'(i);
    end
  end

  // AR sequencing and FIFO pop decisions; oversized requests bypass AR via the completion stage.
  always_comb begin
    state_s   = state_r;
    pop_ar_s  = 1'b0;
    pop_err_s = 1'b0;
    case (state_r)
      AR_IDLE: begin
        if (fifo_ne_s && size_bad_s) begin
          pop_err_s = cpl_free_s && !i_m_rvalid;
        end else if (fifo_ne_s && free_found_s) begin
          pop_ar_s = 1'b1;
          state_s  = AR_ONE;
        end else begin
          state_s = AR_IDLE;
        end
      end
      AR_ONE: begin
        if (i_m_arready) begin
          state_s = split_r ? AR_TWO : AR_IDLE;
        end else begin
          state_s = AR_ONE;
        end
      end
      AR_TWO: begin
        if (i_m_arready) begin
          state_s = AR_IDLE;
        end else begin
          state_s = AR_TWO;
        end
      end
      default: state_s = AR_IDLE;
    endcase
  end

  // Request FIFO storage; occupancy is tracked by the pointers, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r] <= req_addr;
      fifo_len_r[wr_ptr_r]  <= req_len;
      fifo_size_r[wr_ptr_r] <= req_size;
      fifo_tag_r[wr_ptr_r]  <= req_tag;
    end
  end

  // FIFO pointers, occupancy and registered ready (held low until the first edge after reset).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      cnt_r       <= '0;
      req_ready_r <= 1'b0;
      rdy_en_r    <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= (wr_ptr_r == PW'(REQD - 1)) ? '0 : wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= (rd_ptr_r == PW'(REQD - 1)) ? '0 : rd_ptr_r + PW'(1);
      cnt_r       <= cnt_nxt_s;
      req_ready_r <= (cnt_nxt_s != CW'(REQD));
      rdy_en_r    <= 1'b1;
    end
  end

  // AR state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_r <= AR_IDLE;
    else          state_r <= state_s;
  end

  // AR channel registers; the second piece of a split is staged at allocation time.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      arvalid_r <= 1'b0;
      split_r   <= 1'b0;
      arid_r    <= '0;
      araddr_r  <= '0;
      arlen_r   <= '0;
      arsize_r  <= '0;
      addr2_r   <= '0;
      len2_r    <= '0;
    end else if (pop_ar_s) begin
      arvalid_r <= 1'b1;
      split_r   <= cross_s;
      arid_r    <= TAGW'(free_slot_s);
      araddr_r  <= head_addr_s;
      arlen_r   <= cross_s ? len1_s : head_len_s;
      arsize_r  <= head_size_s;
      addr2_r   <= addr2_s;
      len2_r    <= len2_s;
    end else if (state_r == AR_ONE && i_m_arready && split_r) begin
      araddr_r <= addr2_r;
      arlen_r  <= len2_r;
    end else if (state_r != AR_IDLE && i_m_arready) begin
      arvalid_r <= 1'b0;
    end
  end

  // Slot table: allocate on AR pop, count down pieces on each rlast, free on the final one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_r <= '0;
      for (int i = 0; i < NOUT; i++) begin
        slot_tag_r[i]    <= '0;
        slot_pieces_r[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < NOUT; i++) begin
        if (pop_ar_s && free_slot_s == SW'(i)) begin
          busy_r[i]        <= 1'b1;
          slot_tag_r[i]    <= head_tag_s;
          slot_pieces_r[i] <= cross_s ? 2'd2 : 2'd1;
        end else if (hit_s && i_m_rlast && rid_idx_s == SW'(i)) begin
          busy_r[i]        <= (slot_pieces_r[i] != 2'd1);
          slot_pieces_r[i] <= slot_pieces_r[i] - 2'd1;
        end
      end
    end
  end

  // Completion output stage; error completions only load when no R beat can compete.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cpl_valid_r <= 1'b0;
      cpl_tag_r   <= '0;
      cpl_data_r  <= '0;
      cpl_resp_r  <= 2'b00;
      cpl_last_r  <= 1'b0;
    end else if (pop_err_s) begin
      cpl_valid_r <= 1'b1;
      cpl_tag_r   <= head_tag_s;
      cpl_data_r  <= '0;
      cpl_resp_r  <= 2'b10;
      cpl_last_r  <= 1'b1;
    end else if (hit_s) begin
      cpl_valid_r <= 1'b1;
      cpl_tag_r   <= slot_tag_r[rid_idx_s];
      cpl_data_r  <= i_m_rdata;
      cpl_resp_r  <= i_m_rresp;
      cpl_last_r  <= i_m_rlast && last_piece_s;
    end else if (cpl_ready) begin
      cpl_valid_r <= 1'b0;
    end
  end

  // Status counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_cnt_r   <= '0;
      unexp_cnt_r <= 8'd0;
    end else begin
      case ({pop_ar_s, slot_free_s})
        2'b10:   out_cnt_r <= out_cnt_r + OCW'(1);
        2'b01:   out_cnt_r <= out_cnt_r - OCW'(1);
        default: out_cnt_r <= out_cnt_r;
      endcase
      if (unexp_s && unexp_cnt_r != 8'hFF) unexp_cnt_r <= unexp_cnt_r + 8'd1;
    end
  end

  assign req_ready     = req_ready_r;
  assign o_m_arvalid   = arvalid_r;
  assign o_m_arid      = arid_r;
  assign o_m_araddr    = araddr_r;
  assign o_m_arlen     = arlen_r;
  assign o_m_arsize    = arsize_r;
  assign o_m_arburst   = 2'b01;
  assign o_m_arlock    = 1'b0;
  assign o_m_arcache   = 4'b0011;
  assign o_m_arprot    = 3'b000;
  assign o_m_arregion  = 4'b0000;
  assign cpl_valid     = cpl_valid_r;
  assign cpl_tag       = cpl_tag_r;
  assign cpl_data      = cpl_data_r;
  assign cpl_resp      = cpl_resp_r;
  assign cpl_last      = cpl_last_r;
  assign o_outstanding = out_cnt_r;
  assign o_unexp_cnt   = unexp_cnt_r;

endmodule

// File: tb/tb_axi4_m_r_mo.sv
// Scoreboard bench for axi4_m_r_mo: directed requests and R beats, expected AR and
// completion records queued at stimulus time and checked by independent monitors.
module tb_axi4_m_r_mo;
  localparam int TAGW = 3;
  localparam int ADRW = 32;
  localparam int DATW = 256;
  localparam int NOUT = 4;
  localparam int REQD = 4;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [DATW-1:0] data;
    logic [1:0]      resp;
    logic            last;
  } cpl_t;

  typedef struct packed {
    logic [TAGW-1:0] id;
    logic [ADRW-1:0] addr;
    logic [7:0]      len;
    logic [2:0]      size;
  } ar_t;

  logic clk, rst_n;
  logic [ADRW-1:0] req_addr;
  logic [7:0] req_len;
  logic [2:0] req_size;
  logic [TAGW-1:0] req_tag;
  logic req_valid, req_ready;
  logic [TAGW-1:0] arid;
  logic [ADRW-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize, arprot;
  logic [1:0] arburst;
  logic arlock, arvalid, arready;
  logic [3:0] arcache, arregion;
  logic [TAGW-1:0] rid;
  logic [DATW-1:0] rdata;
  logic [1:0] rresp;
  logic rlast, rvalid, rready;
  logic cpl_valid, cpl_ready, cpl_last;
  logic [TAGW-1:0] cpl_tag;
  logic [DATW-1:0] cpl_data;
  logic [1:0] cpl_resp;
  logic [$clog2(NOUT):0] outstanding;
  logic [7:0] unexp_cnt;

  cpl_t cpl_q[$];
  ar_t  ar_q[$];
  cpl_t cpl_e, hold_v;
  ar_t  ar_e;
  logic hold_pend;
  int n_cmp = 0;
  int n_err = 0;
  int ar_seen = 0;
  int ar_base;

  axi4_m_r_mo #(.TAGW(TAGW), .ADRW(ADRW), .DATW(DATW), .NOUT(NOUT), .REQD(REQD)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size), .req_tag(req_tag),
    .req_valid(req_valid), .req_ready(req_ready),
    .o_m_arid(arid), .o_m_araddr(araddr), .o_m_arlen(arlen), .o_m_arsize(arsize),
    .o_m_arburst(arburst), .o_m_arlock(arlock), .o_m_arcache(arcache), .o_m_arprot(arprot),
    .o_m_arregion(arregion), .o_m_arvalid(arvalid), .i_m_arready(arready),
    .i_m_rid(rid), .i_m_rdata(rdata), .i_m_rresp(rresp), .i_m_rlast(rlast),
    .i_m_rvalid(rvalid), .o_m_rready(rready),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag), .cpl_data(cpl_data),
    .cpl_resp(cpl_resp), .cpl_last(cpl_last),
    .o_outstanding(outstanding), .o_unexp_cnt(unexp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DATW-1:0] dat(input int n);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(n);
    return {8{w}};
  endfunction

  // AR monitor
  always @(negedge clk) begin
    if (arvalid && arready) begin
      ar_seen++;
      if (ar_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL ar_unexpected: got id %0d addr %0h len %0d, required no AR", arid, araddr, arlen);
      end else begin
        ar_e = ar_q.pop_front();
        chk("ar_fields", 512'({arid, araddr, arlen, arsize}), 512'(ar_e));
        chk("ar_const", 512'({arburst, arlock, arcache, arprot, arregion}),
            512'({2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000}));
      end
    end
  end

  // Completion monitor
  always @(negedge clk) begin
    if (cpl_valid && cpl_ready) begin
      if (cpl_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL cpl_unexpected: got tag %0d data %0h, required no completion", cpl_tag, cpl_data);
      end else begin
        cpl_e = cpl_q.pop_front();
        chk("cpl", 512'({cpl_tag, cpl_data, cpl_resp, cpl_last}), 512'(cpl_e));
      end
    end
  end

  // Stability monitor for stalled completions
  initial hold_pend = 1'b0;
  always @(negedge clk) begin
    if (hold_pend) chk("cpl_stable", 512'({cpl_valid, cpl_tag, cpl_data, cpl_resp, cpl_last}),
                       512'({1'b1, hold_v}));
    hold_pend = cpl_valid && !cpl_ready && rst_n;
    hold_v    = {cpl_tag, cpl_data, cpl_resp, cpl_last};
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_ar(input logic [TAGW-1:0] id, input logic [ADRW-1:0] a,
                        input logic [7:0] l, input logic [2:0] s);
    ar_t e;
    e.id = id; e.addr = a; e.len = l; e.size = s;
    ar_q.push_back(e);
  endtask

  task automatic exp_cpl(input logic [TAGW-1:0] t, input logic [DATW-1:0] d,
                         input logic [1:0] r, input logic l);
    cpl_t e;
    e.tag = t; e.data = d; e.resp = r; e.last = l;
    cpl_q.push_back(e);
  endtask

  task automatic push_req(input logic [ADRW-1:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [TAGW-1:0] t);
    logic ok;
    ok = 1'b0;
    req_addr = a; req_len = l; req_size = s; req_tag = t; req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      n_cmp++; n_err++;
      $display("FAIL req_timeout: req_ready got 0, required 1 within 100 cycles");
    end
    req_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [TAGW-1:0] id, input logic [DATW-1:0] d,
                           input logic [1:0] r, input logic l);
    logic ok;
    ok = 1'b0;
    rid = id; rdata = d; rresp = r; rlast = l; rvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      n_cmp++; n_err++;
      $display("FAIL r_timeout: rready got 0, required 1 within 100 cycles");
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 200; i++) begin
      if (cpl_q.size() == 0 && ar_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (cpl_q.size() != 0 || ar_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d cpl and %0d ar still pending, required 0", nm,
               cpl_q.size(), ar_q.size());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_addr = '0; req_len = 8'd0; req_size = 3'd0; req_tag = '0; req_valid = 1'b0;
    arready = 1'b1; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    cpl_ready = 1'b1;
    cyc(3);
    chk("rst_outputs", 512'({req_ready, arvalid, rready, cpl_valid, outstanding, unexp_cnt}), 512'(0));
    rst_n = 1'b1;
    cyc(1);
    chk("rst_release_ready", 512'({req_ready, rready}), 512'(2'b11));

    // Unsplit burst
    exp_ar(3'd0, 32'h0000_1000, 8'd3, 3'd5);
    push_req(32'h0000_1000, 8'd3, 3'd5, 3'd5);
    wait_drain("t1_ar");
    chk("t1_outstanding", 512'(outstanding), 512'(1));
    for (int b = 0; b < 4; b++) begin
      exp_cpl(3'd5, dat(b), 2'b00, (b == 3));
      send_beat(3'd0, dat(b), 2'b00, (b == 3));
    end
    wait_drain("t1_cpl");
    cyc(1);
    chk("t1_outstanding_end", 512'(outstanding), 512'(0));

    // 4KB split: 0xFC0 len1, then 0x1000 len1
    exp_ar(3'd0, 32'h0000_0FC0, 8'd1, 3'd5);
    exp_ar(3'd0, 32'h0000_1000, 8'd1, 3'd5);
    push_req(32'h0000_0FC0, 8'd3, 3'd5, 3'd2);
    wait_drain("t2_ar");
    for (int b = 0; b < 4; b++) begin
      exp_cpl(3'd2, dat(10 + b), (b == 1) ? 2'b10 : 2'b00, (b == 3));
      send_beat(3'd0, dat(10 + b), (b == 1) ? 2'b10 : 2'b00, (b == 1 || b == 3));
    end
    wait_drain("t2_cpl");
    cyc(1);
    chk("t2_outstanding_end", 512'(outstanding), 512'(0));

    // Outstanding saturation
    ar_base = ar_seen;
    for (int i = 0; i < 4; i++) exp_ar(3'(i), 32'h0000_2000 + 32'(i * 256), 8'd0, 3'd5);
    for (int i = 0; i < 5; i++) push_req(32'h0000_2000 + 32'(i * 256), 8'd0, 3'd5, 3'(i + 1));
    cyc(20);
    chk("t3_ar_count", 512'(ar_seen - ar_base), 512'(4));
    chk("t3_outstanding_full", 512'(outstanding), 512'(4));
    exp_ar(3'd2, 32'h0000_2400, 8'd0, 3'd5);
    exp_cpl(3'd3, dat(20), 2'b00, 1'b1);
    send_beat(3'd2, dat(20), 2'b00, 1'b1);
    wait_drain("t3_fifth");
    chk("t3_outstanding_refill", 512'(outstanding), 512'(4));
    exp_cpl(3'd1, dat(21), 2'b00, 1'b1); send_beat(3'd0, dat(21), 2'b00, 1'b1);
    exp_cpl(3'd2, dat(22), 2'b00, 1'b1); send_beat(3'd1, dat(22), 2'b00, 1'b1);
    exp_cpl(3'd4, dat(23), 2'b01, 1'b1); send_beat(3'd3, dat(23), 2'b01, 1'b1);
    exp_cpl(3'd5, dat(24), 2'b00, 1'b1); send_beat(3'd2, dat(24), 2'b00, 1'b1);
    wait_drain("t3_cpl");
    cyc(1);
    chk("t3_outstanding_end", 512'(outstanding), 512'(0));

    // Completion backpressure mid-burst
    exp_ar(3'd0, 32'h0000_3000, 8'd5, 3'd5);
    push_req(32'h0000_3000, 8'd5, 3'd5, 3'd6);
    wait_drain("t4_ar");
    for (int b = 0; b < 6; b++) exp_cpl(3'd6, dat(30 + b), 2'b00, (b == 5));
    send_beat(3'd0, dat(30), 2'b00, 1'b0);
    send_beat(3'd0, dat(31), 2'b00, 1'b0);
    cyc(1);
    fork
      begin
        for (int b = 2; b < 6; b++) send_beat(3'd0, dat(30 + b), 2'b00, (b == 5));
      end
      begin
        cpl_ready = 1'b0;
        cyc(3);
        @(negedge clk);
        chk("t4_rready_low", 512'({rready, cpl_valid}), 512'(2'b01));
        chk("t4_held_data", 512'(cpl_data), 512'(dat(32)));
        cyc(7);
        cpl_ready = 1'b1;
      end
    join
    wait_drain("t4_cpl");

    // Unexpected IDs: free slot and out-of-range
    send_beat(3'd2, dat(40), 2'b00, 1'b1);
    cyc(3);
    chk("t5_unexp_free", 512'({unexp_cnt, cpl_valid}), 512'({8'd1, 1'b0}));
    send_beat(3'd7, dat(41), 2'b00, 1'b0);
    cyc(3);
    chk("t5_unexp_range", 512'(unexp_cnt), 512'(2));

    // Oversized beat size: error completion, no AR
    exp_cpl(3'd4, '0, 2'b10, 1'b1);
    push_req(32'h0000_6000, 8'd0, 3'd6, 3'd4);
    wait_drain("t6_err");
    cyc(2);
    chk("t6_outstanding", 512'(outstanding), 512'(0));

    // Reset mid-burst with two slots busy
    exp_ar(3'd0, 32'h0000_4000, 8'd3, 3'd5);
    exp_ar(3'd1, 32'h0000_5000, 8'd3, 3'd5);
    push_req(32'h0000_4000, 8'd3, 3'd5, 3'd1);
    push_req(32'h0000_5000, 8'd3, 3'd5, 3'd2);
    wait_drain("t7_ar");
    exp_cpl(3'd1, dat(50), 2'b00, 1'b0);
    send_beat(3'd0, dat(50), 2'b00, 1'b0);
    wait_drain("t7_cpl");
    chk("t7_outstanding_busy", 512'(outstanding), 512'(2));
    rst_n = 1'b0;
    #1;
    chk("t7_rst_immediate", 512'({req_ready, arvalid, rready, cpl_valid, outstanding, unexp_cnt}), 512'(0));
    cpl_q.delete();
    ar_q.delete();
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    chk("t7_after_release", 512'({req_ready, outstanding}), 512'({1'b1, 3'd0}));
    exp_ar(3'd0, 32'h0000_1000, 8'd0, 3'd5);
    push_req(32'h0000_1000, 8'd0, 3'd5, 3'd3);
    wait_drain("t7_new_ar");
    exp_cpl(3'd3, dat(60), 2'b00, 1'b1);
    send_beat(3'd0, dat(60), 2'b00, 1'b1);
    wait_drain("t7_new_cpl");
    cyc(1);
    chk("t7_outstanding_end", 512'(outstanding), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
